// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: next-address mode encodings.
package pc_seq_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_SEQ    = 3'b000,
        MODE_BRANCH = 3'b001,
        MODE_JUMP   = 3'b010,
        MODE_CALL   = 3'b011,
        MODE_RET    = 3'b100
    } mode_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ret_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top_data,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);
    import pc_seq_pkg::*;

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];

    assign full     = (count_q == CNT_W'(RAS_DEPTH));
    assign empty    = (count_q == '0);
    assign top_data = mem_q[top_q];
    assign count    = count_q;

    // The pointer wraps naturally, so when full the next slot is the oldest entry.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push) begin
            top_d        = top_q + PTR_W'(1);
            mem_d[top_d] = push_data;
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction address generator: next-PC mux, alignment enforcement, RAS and sticky error flags.
module pc_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                INC        = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                RAS_DEPTH  = 4,
    parameter int                ALIGN_BITS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pc_enable,
    input  logic [2:0]                  mode,
    input  logic                        cond,
    input  logic [ADDR_W-1:0]           branch_off,
    input  logic [ADDR_W-1:0]           target,
    output logic [ADDR_W-1:0]           pc,
    output logic [ADDR_W-1:0]           pc_prev,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow,
    output logic                        misalign_err,
    output logic                        illegal_mode
);
    import pc_seq_pkg::*;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_prev_q, pc_prev_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              misalign_q, misalign_d, illegal_q, illegal_d;

    logic [ADDR_W-1:0] seq_addr, raw_next, ras_top;
    logic              push_req, pop_req, underflow_ev, bad_mode;
    logic              ras_full, ras_empty;

    ret_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (pc_enable && push_req),
        .pop       (pc_enable && pop_req),
        .push_data (seq_addr & ~ALIGN_MASK),
        .top_data  (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        seq_addr     = pc_q + ADDR_W'(INC);
        raw_next     = seq_addr;
        push_req     = 1'b0;
        pop_req      = 1'b0;
        underflow_ev = 1'b0;
        bad_mode     = 1'b0;
        case (mode)
            MODE_SEQ:    raw_next = seq_addr;
            MODE_BRANCH: raw_next = cond ? (pc_q + branch_off) : seq_addr;
            MODE_JUMP:   raw_next = target;
            MODE_CALL: begin
                raw_next = target;
                push_req = 1'b1;
            end
            MODE_RET: begin
                if (ras_empty) begin
                    raw_next     = target;
                    underflow_ev = 1'b1;
                end else begin
                    raw_next = ras_top;
                    pop_req  = 1'b1;
                end
            end
            default:     bad_mode = 1'b1;
        endcase
    end

    // Misaligned addresses are still taken, with the low bits cleared.
    always_comb begin
        pc_d        = pc_q;
        pc_prev_d   = pc_prev_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        misalign_d  = misalign_q;
        illegal_d   = illegal_q;
        if (pc_enable) begin
            pc_prev_d   = pc_q;
            pc_d        = raw_next & ~ALIGN_MASK;
            misalign_d  = misalign_q | (|(raw_next & ALIGN_MASK));
            overflow_d  = overflow_q | (push_req & ras_full);
            underflow_d = underflow_q | underflow_ev;
            illegal_d   = illegal_q | bad_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VEC;
            pc_prev_q   <= RESET_VEC;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_prev_q   <= pc_prev_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
            illegal_q   <= illegal_d;
        end
    end

    assign pc            = pc_q;
    assign pc_prev       = pc_prev_q;
    assign ras_overflow  = overflow_q;
    assign ras_underflow = underflow_q;
    assign misalign_err  = misalign_q;
    assign illegal_mode  = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expected addresses and flags.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        pc_enable;
    logic [2:0]  mode;
    logic        cond;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_prev;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        misalign_err;
    logic        illegal_mode;

    int vectorCount = 0;
    int failCount   = 0;

    localparam logic [2:0] SEQ = 3'b000, BRA = 3'b001, JMP = 3'b010, CAL = 3'b011, RET = 3'b100;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pc_enable     (pc_enable),
        .mode          (mode),
        .cond          (cond),
        .branch_off    (branch_off),
        .target        (target),
        .pc            (pc),
        .pc_prev       (pc_prev),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .misalign_err  (misalign_err),
        .illegal_mode  (illegal_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] m,
                                 input logic c, input logic [31:0] off, input logic [31:0] tgt);
        reset      = rst;
        pc_enable  = en;
        mode       = m;
        cond       = c;
        branch_off = off;
        target     = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkFlags(input string tag, input logic ov, input logic un,
                              input logic mis, input logic ill);
        checkOutput({tag, ".ovf"}, {31'd0, ras_overflow},  {31'd0, ov});
        checkOutput({tag, ".unf"}, {31'd0, ras_underflow}, {31'd0, un});
        checkOutput({tag, ".mis"}, {31'd0, misalign_err},  {31'd0, mis});
        checkOutput({tag, ".ill"}, {31'd0, illegal_mode},  {31'd0, ill});
    endtask

    logic [31:0] callPc   [5] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h400};
    logic [31:0] retExp   [5] = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h800};
    logic [2:0]  retCount [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

    initial begin
        reset = 1'b1; pc_enable = 1'b0; mode = SEQ; cond = 1'b0; branch_off = '0; target = '0;

        // Reset state
        applyStimulus(1, 1, SEQ, 0, 0, 0);
        applyStimulus(1, 0, SEQ, 0, 0, 0);
        checkOutput("rst.pc", pc, 32'h0);
        checkOutput("rst.prev", pc_prev, 32'h0);
        checkOutput("rst.cnt", {29'd0, ras_count}, 32'd0);
        checkFlags("rst", 0, 0, 0, 0);

        // Sequential stepping
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 1, SEQ, 0, 0, 0);
            checkOutput($sformatf("seq%0d.pc", i), pc, 32'(4 * i));
            checkOutput($sformatf("seq%0d.prev", i), pc_prev, 32'(4 * (i - 1)));
        end

        // Branch taken / not taken, then stall
        applyStimulus(0, 1, JMP, 0, 0, 32'h20);
        applyStimulus(0, 1, BRA, 1, 32'hFFFF_FFF8, 0);
        checkOutput("bra.taken", pc, 32'h18);
        checkOutput("bra.taken.prev", pc_prev, 32'h20);
        applyStimulus(0, 1, JMP, 0, 0, 32'h20);
        applyStimulus(0, 1, BRA, 0, 32'hFFFF_FFF8, 0);
        checkOutput("bra.nt", pc, 32'h24);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, JMP, 1, 32'h40, 32'h999);
            checkOutput($sformatf("stall%0d.pc", i), pc, 32'h24);
            checkOutput($sformatf("stall%0d.prev", i), pc_prev, 32'h20);
        end

        // Call and return
        applyStimulus(0, 1, JMP, 0, 0, 32'h40);
        applyStimulus(0, 1, CAL, 0, 0, 32'h100);
        checkOutput("call.pc", pc, 32'h100);
        checkOutput("call.cnt", {29'd0, ras_count}, 32'd1);
        applyStimulus(0, 1, RET, 0, 0, 32'h900);
        checkOutput("ret.pc", pc, 32'h44);
        checkOutput("ret.cnt", {29'd0, ras_count}, 32'd0);
        checkFlags("callret", 0, 0, 0, 0);

        // RAS overflow then underflow
        applyStimulus(1, 0, SEQ, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("ovf%0d.pcIn", i), pc, callPc[i]);
            applyStimulus(0, 1, CAL, 0, 0, callPc[i] + 32'h100);
            checkOutput($sformatf("ovf%0d.flag", i), {31'd0, ras_overflow}, {31'd0, (i == 4)});
        end
        checkOutput("ovf.cnt", {29'd0, ras_count}, 32'd4);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, RET, 0, 0, 32'h800);
            checkOutput($sformatf("ret%0d.pc", i), pc, retExp[i]);
            checkOutput($sformatf("ret%0d.cnt", i), {29'd0, ras_count}, {29'd0, retCount[i]});
            checkOutput($sformatf("ret%0d.unf", i), {31'd0, ras_underflow}, {31'd0, (i == 4)});
        end

        // Wrap, alignment and reserved modes
        applyStimulus(1, 0, SEQ, 0, 0, 0);
        applyStimulus(0, 0, 3'b111, 0, 0, 0);
        checkOutput("illStall.pc", pc, 32'h0);
        checkFlags("illStall", 0, 0, 0, 0);
        applyStimulus(0, 1, JMP, 0, 0, 32'hFFFF_FFFC);
        applyStimulus(0, 1, SEQ, 0, 0, 0);
        checkOutput("wrap.pc", pc, 32'h0);
        checkOutput("wrap.prev", pc_prev, 32'hFFFF_FFFC);
        checkFlags("wrap", 0, 0, 0, 0);
        applyStimulus(0, 1, JMP, 0, 0, 32'h103);
        checkOutput("mis.pc", pc, 32'h100);
        checkFlags("mis", 0, 0, 1, 0);
        applyStimulus(0, 1, 3'b110, 1, 32'h40, 32'h500);
        checkOutput("ill.pc", pc, 32'h104);
        checkFlags("ill", 0, 0, 1, 1);

        // Reset in the middle of a call sequence
        applyStimulus(0, 1, CAL, 0, 0, 32'h200);
        checkOutput("midCall.cnt", {29'd0, ras_count}, 32'd1);
        applyStimulus(1, 1, CAL, 0, 0, 32'h300);
        checkOutput("midRst.pc", pc, 32'h0);
        checkOutput("midRst.prev", pc_prev, 32'h0);
        checkOutput("midRst.cnt", {29'd0, ras_count}, 32'd0);
        checkFlags("midRst", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation instruction address generator for the Project 1 datapath.
- Holds the PC and the previous PC, and selects the next address from five sources: sequential increment, conditional relative branch, absolute jump, call and return.
- Adds a hardware return-address stack (RAS), a stall enable, synchronous reset to a programmable vector, and sticky error flags.
- Feeds instruction memory; its inputs come from the decode/control unit and the register file.

Parameters:
- ADDR_W, 32, width of PC, targets and offsets
- INC, 4, sequential increment in bytes
- RESET_VEC, 0, PC value after reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- ALIGN_BITS, 2, low PC bits that must be zero

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- pc_enable  in  1  advance PC this cycle; 0 = stall
- mode  in  3  next-address mode (encodings in package)
- cond  in  1  branch condition, used in BRANCH mode only
- branch_off  in  ADDR_W  signed two's-complement byte offset
- target  in  ADDR_W  absolute/register target (JUMP, CALL, RET fallback)
- pc  out  ADDR_W  current instruction address
- pc_prev  out  ADDR_W  address of the previously issued instruction
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  out  1  sticky: push occurred with RAS full
- ras_underflow  out  1  sticky: pop occurred with RAS empty
- misalign_err  out  1  sticky: computed next PC had nonzero low ALIGN_BITS
- illegal_mode  out  1  sticky: reserved mode code seen while enabled

Behaviour:
- Reset (Reset=1 at a rising edge, regardless of pc_enable or a mid-operation mode):
  - pc = pc_prev = RESET_VEC.
  - ras_count = 0; all sticky flags = 0; RAS contents don't-care.
- pc_enable=0: all state and outputs hold, including pc_prev and the RAS.
- pc_enable=1 at a rising edge: pc_prev <= pc, and pc <= next, where next is:
  - SEQ (000): pc+INC.
  - BRANCH (001): cond ? pc+branch_off : pc+INC.
  - JUMP (010): target.
  - CALL (011): target; push pc+INC onto the RAS.
  - RET (100): pop the RAS top. If ras_count==0, use target, set ras_underflow, ras_count stays 0.
  - 101–111: treated as SEQ; set illegal_mode.
- Arithmetic is modulo 2^ADDR_W: wrap-around is silent and no carry is kept. branch_off is sign-interpreted at full width.
- Alignment: if next[ALIGN_BITS-1:0] != 0, set misalign_err and load pc with those bits forced to 0. Pushed return addresses are aligned the same way.
- RAS is circular with a top pointer:
  - Push when full overwrites the oldest entry, sets ras_overflow, and ras_count saturates at RAS_DEPTH.
  - Pop decrements ras_count.
- Latency: next address is combinational from current state and inputs; pc is registered, so one-cycle latency from mode to pc. No combinational path from inputs to any output.
- Sticky flags clear only on Reset.

Decomposition:
- Shared package pc_seq_pkg holds:
  - mode encodings (MODE_SEQ, MODE_BRANCH, MODE_JUMP, MODE_CALL, MODE_RET);
  - mode width constant = 3.
- One sub-module, ret_addr_stack:
  - parameters ADDR_W and RAS_DEPTH;
  - ports: push, pop, push_data, top_data, count, full, empty;
  - handles circular overwrite-on-full.
- Top level holds the next-PC mux, adder, alignment check and flags.

Test Plan:
- Reset then 3 SEQ cycles (defaults) -> pc 0,4,8,12; pc_prev 0,0,4,8.
- BRANCH with pc=0x20, branch_off=-8: cond=1 -> pc=0x18; cond=0 -> pc=0x24. pc_enable=0 for 2 cycles -> pc and pc_prev hold.
- CALL target=0x100 at pc=0x40, then RET -> pc 0x100 then 0x44; ras_count 1 then 0; no flags set.
- 5 CALLs (RAS_DEPTH=4) from pc=0x0,0x100,0x200,0x300,0x400, each target=pc+0x100 -> ras_overflow=1, ras_count=4. Then 5 RETs with target=0x800 -> 0x404,0x304,0x204,0x104, then 0x800 with ras_underflow=1.
- Wrap and alignment: pc=0xFFFFFFFC SEQ -> pc=0; JUMP target=0x103 -> pc=0x100, misalign_err=1. mode=110 -> SEQ step and illegal_mode=1.
- Reset asserted mid-CALL sequence with pc_enable=1 -> pc=RESET_VEC, ras_count=0, all flags 0 on the next cycle.
